// File: rtl/subr_pkg.sv
// Shared encodings for the subroutine/return-address sequencer: request ops,
// fault codes, controller states and the default interrupt entry address.
package subr_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_CALL = 2'b01,
    OP_RET  = 2'b10,
    OP_IRET = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    FLT_NONE = 2'b00,
    FLT_OVF  = 2'b01,
    FLT_UNF  = 2'b10,
    FLT_IRET = 2'b11
  } flt_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_POP_WAIT = 2'b01,
    ST_FAULT    = 2'b10
  } state_e;

  localparam logic [10:0] INT_VEC_DEFAULT = 11'h7F0;

endpackage

// File: rtl/ret_stack_mem.sv
// Return-address storage: DEPTH x PC_W array, synchronous write and a
// registered read port with one cycle of latency. The array is never reset.
module ret_stack_mem #(
  parameter int PC_W  = 19,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [PC_W-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_addr,
  output logic [PC_W-1:0] rd_data
);

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [PC_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/subroutine_seq.sv
// Return-address stack sequencer: arbitrates CALL/RET/IRET against IRQ entry
// and redirects the PC. Optional macro SUBR_IRQ_RESERVE_EN keeps one slot for IRQ.
module subroutine_seq
  import subr_pkg::*;
#(
  parameter int                PC_W    = 19,
  parameter int                ADDR_W  = 11,
  parameter int                DEPTH   = 16,
  parameter logic [ADDR_W-1:0] INT_VEC = INT_VEC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [PC_W-1:0]        pc_current,
  input  logic [ADDR_W-1:0]      call_addr,
  input  logic                   irq,
  output logic                   irq_ack,
  input  logic                   program_end,
  output logic                   resp_valid,
  output logic [PC_W-1:0]        pc_next,
  output logic                   in_isr,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   fault,
  output logic [1:0]             fault_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;
`ifdef SUBR_IRQ_RESERVE_EN
  localparam logic [DW-1:0] CALL_FULL = DW'(DEPTH - 1);
`else
  localparam logic [DW-1:0] CALL_FULL = DW'(DEPTH);
`endif
  localparam logic [DW-1:0] IRQ_FULL = DW'(DEPTH);

  state_e          state_q, state_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic            in_isr_q, in_isr_d;
  logic            fault_q, fault_d;
  flt_e            code_q, code_d;
  logic            resp_valid_q, resp_valid_d;
  logic [PC_W-1:0] pc_next_q, pc_next_d;
  logic            pop_iret_q, pop_iret_d;

  logic            irq_take, accept;
  logic            wr_en, rd_en;
  logic [PC_W-1:0] wr_data, rd_data;
  logic [AW-1:0]   wr_addr, rd_addr;

  // Interrupt entry wins over a simultaneous request, which stays pending.
  assign irq_take  = !reset && (state_q == ST_IDLE) && irq && !in_isr_q
                     && !program_end && !fault_q;
  assign req_ready = !reset && (state_q == ST_IDLE) && !program_end
                     && !fault_q && !irq_take;
  assign accept    = req_valid && req_ready;

  assign wr_addr = depth_q[AW-1:0];
  assign rd_addr = depth_q[AW-1:0] - AW'(1);

  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    in_isr_d     = in_isr_q;
    fault_d      = fault_q;
    code_d       = code_q;
    resp_valid_d = 1'b0;
    pc_next_d    = pc_next_q;
    pop_iret_d   = pop_iret_q;
    wr_en        = 1'b0;
    wr_data      = pc_current;
    rd_en        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (irq_take) begin
          if (depth_q >= IRQ_FULL) begin
            fault_d = 1'b1;
            code_d  = FLT_OVF;
            state_d = ST_FAULT;
          end else begin
            wr_en        = 1'b1;
            wr_data      = pc_current;
            depth_d      = depth_q + DW'(1);
            in_isr_d     = 1'b1;
            resp_valid_d = 1'b1;
            pc_next_d    = PC_W'(INT_VEC);
          end
        end else if (accept) begin
          case (op_e'(req_op))
            OP_CALL: begin
              if (depth_q >= CALL_FULL) begin
                fault_d = 1'b1;
                code_d  = FLT_OVF;
                state_d = ST_FAULT;
              end else begin
                wr_en        = 1'b1;
                wr_data      = pc_current + PC_W'(1);
                depth_d      = depth_q + DW'(1);
                resp_valid_d = 1'b1;
                pc_next_d    = PC_W'(call_addr);
              end
            end
            OP_RET, OP_IRET: begin
              // An IRET outside an ISR is reported ahead of an empty stack.
              if ((req_op == OP_IRET) && !in_isr_q) begin
                fault_d = 1'b1;
                code_d  = FLT_IRET;
                state_d = ST_FAULT;
              end else if (depth_q == '0) begin
                fault_d = 1'b1;
                code_d  = FLT_UNF;
                state_d = ST_FAULT;
              end else begin
                rd_en      = 1'b1;
                depth_d    = depth_q - DW'(1);
                pop_iret_d = (req_op == OP_IRET);
                state_d    = ST_POP_WAIT;
              end
            end
            default: ;
          endcase
        end
      end
      ST_POP_WAIT: begin
        resp_valid_d = 1'b1;
        pc_next_d    = rd_data;
        if (pop_iret_q) in_isr_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      depth_q      <= '0;
      in_isr_q     <= 1'b0;
      fault_q      <= 1'b0;
      code_q       <= FLT_NONE;
      resp_valid_q <= 1'b0;
      pc_next_q    <= '0;
      pop_iret_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      depth_q      <= depth_d;
      in_isr_q     <= in_isr_d;
      fault_q      <= fault_d;
      code_q       <= code_d;
      resp_valid_q <= resp_valid_d;
      pc_next_q    <= pc_next_d;
      pop_iret_q   <= pop_iret_d;
    end
  end

  ret_stack_mem #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign irq_ack    = irq_take;
  assign resp_valid = resp_valid_q;
  assign pc_next    = pc_next_q;
  assign in_isr     = in_isr_q;
  assign depth      = depth_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_subroutine_seq.sv
// Scenario bench for subroutine_seq: directed cases plus a randomized run
// checked against a queue-based model of the return stack.
module tb_subroutine_seq;

  localparam int PC_W   = 19;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 16;
  localparam int DW     = $clog2(DEPTH) + 1;
  localparam logic [PC_W-1:0] INT_PC = 19'h007F0;
`ifdef SUBR_IRQ_RESERVE_EN
  localparam int CALL_CAP = DEPTH - 1;
`else
  localparam int CALL_CAP = DEPTH;
`endif

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [PC_W-1:0]   pc_current;
  logic [ADDR_W-1:0] call_addr;
  logic              irq;
  logic              irq_ack;
  logic              program_end;
  logic              resp_valid;
  logic [PC_W-1:0]   pc_next;
  logic              in_isr;
  logic [DW-1:0]     depth;
  logic              fault;
  logic [1:0]        fault_code;

  int n_assert = 0;
  int n_fail   = 0;

  subroutine_seq dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .pc_current  (pc_current),
    .call_addr   (call_addr),
    .irq         (irq),
    .irq_ack     (irq_ack),
    .program_end (program_end),
    .resp_valid  (resp_valid),
    .pc_next     (pc_next),
    .in_isr      (in_isr),
    .depth       (depth),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid   = 1'b0;
    req_op      = 2'b00;
    pc_current  = '0;
    call_addr   = '0;
    irq         = 1'b0;
    program_end = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_assert++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
    n_assert++; if (pc_next !== '0) begin n_fail++; $display("FAIL rst_pc_next got %h want 0", pc_next); end
    n_assert++; if (depth !== '0) begin n_fail++; $display("FAIL rst_depth got %0d want 0", depth); end
    n_assert++; if (fault !== 1'b0 || fault_code !== 2'b00) begin n_fail++; $display("FAIL rst_fault got %b/%b want 0/00", fault, fault_code); end
    n_assert++; if (in_isr !== 1'b0 || irq_ack !== 1'b0) begin n_fail++; $display("FAIL rst_isr got %b/%b want 0/0", in_isr, irq_ack); end
    n_assert++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", req_ready); end
  endtask

  task automatic test_nested_calls();
    do_reset();
    req_valid = 1'b1; req_op = 2'b01; pc_current = 19'h00010; call_addr = 11'h100;
    #1;
    n_assert++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL nest_ready got %b want 1", req_ready); end
    tick();
    n_assert++; if (resp_valid !== 1'b1 || pc_next !== 19'h00100 || depth !== 5'd1) begin n_fail++; $display("FAIL nest_call1 got rv=%b pc=%h d=%0d want 1/00100/1", resp_valid, pc_next, depth); end
    pc_current = 19'h00100; call_addr = 11'h200;
    tick();
    n_assert++; if (resp_valid !== 1'b1 || pc_next !== 19'h00200 || depth !== 5'd2) begin n_fail++; $display("FAIL nest_call2 got rv=%b pc=%h d=%0d want 1/00200/2", resp_valid, pc_next, depth); end
    req_op = 2'b10;
    tick();
    req_valid = 1'b0;
    #1;
    n_assert++; if (resp_valid !== 1'b0 || depth !== 5'd1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL nest_ret1_wait got rv=%b d=%0d rdy=%b want 0/1/0", resp_valid, depth, req_ready); end
    tick();
    n_assert++; if (resp_valid !== 1'b1 || pc_next !== 19'h00101 || depth !== 5'd1) begin n_fail++; $display("FAIL nest_ret1 got rv=%b pc=%h d=%0d want 1/00101/1", resp_valid, pc_next, depth); end
    req_valid = 1'b1; req_op = 2'b10;
    tick();
    req_valid = 1'b0;
    n_assert++; if (resp_valid !== 1'b0 || depth !== 5'd0) begin n_fail++; $display("FAIL nest_ret2_wait got rv=%b d=%0d want 0/0", resp_valid, depth); end
    tick();
    n_assert++; if (resp_valid !== 1'b1 || pc_next !== 19'h00011 || depth !== 5'd0) begin n_fail++; $display("FAIL nest_ret2 got rv=%b pc=%h d=%0d want 1/00011/0", resp_valid, pc_next, depth); end
    // Return address of a CALL at the top of the PC range wraps to zero.
    req_valid = 1'b1; req_op = 2'b01; pc_current = '1; call_addr = 11'h3;
    tick();
    req_op = 2'b10;
    tick();
    req_valid = 1'b0;
    tick();
    n_assert++; if (resp_valid !== 1'b1 || pc_next !== 19'h00000) begin n_fail++; $display("FAIL nest_wrap got rv=%b pc=%h want 1/00000", resp_valid, pc_next); end
  endtask

  task automatic test_irq_vs_call();
    do_reset();
    req_valid = 1'b1; req_op = 2'b01; pc_current = 19'h00050; call_addr = 11'h123; irq = 1'b1;
    #1;
    n_assert++; if (irq_ack !== 1'b1 || req_ready !== 1'b0) begin n_fail++; $display("FAIL irq_arb got ack=%b rdy=%b want 1/0", irq_ack, req_ready); end
    tick();
    irq = 1'b0;
    #1;
    n_assert++; if (resp_valid !== 1'b1 || pc_next !== INT_PC || in_isr !== 1'b1 || depth !== 5'd1) begin n_fail++; $display("FAIL irq_entry got rv=%b pc=%h isr=%b d=%0d want 1/007f0/1/1", resp_valid, pc_next, in_isr, depth); end
    n_assert++; if (irq_ack !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL irq_held_ready got ack=%b rdy=%b want 0/1", irq_ack, req_ready); end
    tick();
    req_valid = 1'b0;
    n_assert++; if (resp_valid !== 1'b1 || pc_next !== 19'h00123 || depth !== 5'd2) begin n_fail++; $display("FAIL irq_held_call got rv=%b pc=%h d=%0d want 1/00123/2", resp_valid, pc_next, depth); end
    req_valid = 1'b1; req_op = 2'b10;
    tick();
    req_valid = 1'b0;
    tick();
    n_assert++; if (resp_valid !== 1'b1 || pc_next !== 19'h00051) begin n_fail++; $display("FAIL irq_ret got rv=%b pc=%h want 1/00051", resp_valid, pc_next); end
    req_valid = 1'b1; req_op = 2'b11;
    tick();
    req_valid = 1'b0;
    n_assert++; if (in_isr !== 1'b1 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL iret_wait got isr=%b rv=%b want 1/0", in_isr, resp_valid); end
    tick();
    n_assert++; if (resp_valid !== 1'b1 || pc_next !== 19'h00050 || in_isr !== 1'b0 || depth !== 5'd0) begin n_fail++; $display("FAIL iret got rv=%b pc=%h isr=%b d=%0d want 1/00050/0/0", resp_valid, pc_next, in_isr, depth); end
  endtask

  task automatic test_overflow();
    do_reset();
    req_valid = 1'b1; req_op = 2'b01;
    for (int i = 0; i < CALL_CAP; i++) begin
      pc_current = PC_W'(i * 4); call_addr = ADDR_W'(i + 1);
      tick();
      n_assert++; if (resp_valid !== 1'b1 || pc_next !== PC_W'(i + 1) || fault !== 1'b0) begin n_fail++; $display("FAIL ovf_fill%0d got rv=%b pc=%h f=%b want 1/%h/0", i, resp_valid, pc_next, fault, PC_W'(i + 1)); end
    end
    tick();
    n_assert++; if (fault !== 1'b1 || fault_code !== 2'b01 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_fault got f=%b code=%b rv=%b want 1/01/0", fault, fault_code, resp_valid); end
    n_assert++; if (depth !== DW'(CALL_CAP)) begin n_fail++; $display("FAIL ovf_depth got %0d want %0d", depth, CALL_CAP); end
    irq = 1'b1;
    #1;
    n_assert++; if (req_ready !== 1'b0 || irq_ack !== 1'b0) begin n_fail++; $display("FAIL ovf_blocked got rdy=%b ack=%b want 0/0", req_ready, irq_ack); end
    tick();
    tick();
    n_assert++; if (fault !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0 || depth !== DW'(CALL_CAP)) begin n_fail++; $display("FAIL ovf_sticky got f=%b rdy=%b rv=%b d=%0d want 1/0/0/%0d", fault, req_ready, resp_valid, depth, CALL_CAP); end
    do_reset();
    n_assert++; if (fault !== 1'b0 || fault_code !== 2'b00) begin n_fail++; $display("FAIL ovf_clear got f=%b code=%b want 0/00", fault, fault_code); end
  endtask

  task automatic test_irq_full();
    do_reset();
    req_valid = 1'b1; req_op = 2'b01;
    for (int i = 0; i < CALL_CAP; i++) begin
      pc_current = PC_W'(i); call_addr = ADDR_W'(i);
      tick();
    end
    req_valid = 1'b0; irq = 1'b1; pc_current = 19'h00077;
    #1;
`ifdef SUBR_IRQ_RESERVE_EN
    n_assert++; if (irq_ack !== 1'b1) begin n_fail++; $display("FAIL irqfull_ack got %b want 1", irq_ack); end
    tick();
    irq = 1'b0;
    n_assert++; if (resp_valid !== 1'b1 || pc_next !== INT_PC || depth !== DW'(DEPTH) || in_isr !== 1'b1 || fault !== 1'b0) begin n_fail++; $display("FAIL irqfull_push got rv=%b pc=%h d=%0d isr=%b f=%b", resp_valid, pc_next, depth, in_isr, fault); end
`else
    tick();
    irq = 1'b0;
    n_assert++; if (fault !== 1'b1 || fault_code !== 2'b01 || resp_valid !== 1'b0 || depth !== DW'(DEPTH) || in_isr !== 1'b0) begin n_fail++; $display("FAIL irqfull_fault got f=%b code=%b rv=%b d=%0d isr=%b", fault, fault_code, resp_valid, depth, in_isr); end
`endif
  endtask

  task automatic test_underflow_iret();
    do_reset();
    req_valid = 1'b1; req_op = 2'b10;
    tick();
    req_valid = 1'b0;
    n_assert++; if (fault !== 1'b1 || fault_code !== 2'b10 || resp_valid !== 1'b0 || depth !== 5'd0) begin n_fail++; $display("FAIL unf got f=%b code=%b rv=%b d=%0d want 1/10/0/0", fault, fault_code, resp_valid, depth); end
    do_reset();
    req_valid = 1'b1; req_op = 2'b01; pc_current = 19'h00020; call_addr = 11'h40;
    tick();
    req_op = 2'b11;
    tick();
    req_valid = 1'b0;
    n_assert++; if (fault !== 1'b1 || fault_code !== 2'b11 || resp_valid !== 1'b0 || depth !== 5'd1) begin n_fail++; $display("FAIL iret_illegal got f=%b code=%b rv=%b d=%0d want 1/11/0/1", fault, fault_code, resp_valid, depth); end
  endtask

  task automatic test_halt();
    do_reset();
    req_valid = 1'b1; req_op = 2'b01; pc_current = 19'h00200; call_addr = 11'h300;
    tick();
    req_op = 2'b10;
    tick();
    req_valid = 1'b0; program_end = 1'b1;
    tick();
    n_assert++; if (resp_valid !== 1'b1 || pc_next !== 19'h00201) begin n_fail++; $display("FAIL halt_resp got rv=%b pc=%h want 1/00201", resp_valid, pc_next); end
    irq = 1'b1; req_valid = 1'b1; req_op = 2'b01;
    #1;
    n_assert++; if (req_ready !== 1'b0 || irq_ack !== 1'b0) begin n_fail++; $display("FAIL halt_block got rdy=%b ack=%b want 0/0", req_ready, irq_ack); end
    tick();
    n_assert++; if (resp_valid !== 1'b0 || depth !== 5'd0 || in_isr !== 1'b0 || irq_ack !== 1'b0) begin n_fail++; $display("FAIL halt_idle got rv=%b d=%0d isr=%b ack=%b want 0/0/0/0", resp_valid, depth, in_isr, irq_ack); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    irq = 1'b1; pc_current = 19'h00040;
    tick();
    irq = 1'b0; req_valid = 1'b1; req_op = 2'b01; call_addr = 11'h10;
    tick();
    req_op = 2'b10;
    tick();
    req_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_assert++; if (depth !== 5'd0 || resp_valid !== 1'b0 || fault !== 1'b0 || in_isr !== 1'b0) begin n_fail++; $display("FAIL rstmid got d=%0d rv=%b f=%b isr=%b want 0/0/0/0", depth, resp_valid, fault, in_isr); end
    n_assert++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b want 1", req_ready); end
  endtask

  task automatic test_random();
    logic [PC_W-1:0] stk[$];
    logic            m_isr, m_fault;
    logic [1:0]      m_code;
    logic            e1_v, e1_clr, n1_v, n2_v, n2_clr, cur_v, cur_clr;
    logic [PC_W-1:0] e1_pc, n1_pc, n2_pc, cur_pc;
    logic            busy, take, rdy;
    int              r;
    do_reset();
    stk.delete(); m_isr = 0; m_fault = 0; m_code = 0; e1_v = 0; e1_clr = 0; e1_pc = '0;
    for (int c = 0; c < 800; c++) begin
      if ((m_fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        do_reset();
        stk.delete(); m_isr = 0; m_fault = 0; m_code = 0; e1_v = 0; e1_clr = 0; e1_pc = '0;
      end
      req_valid = ($urandom_range(0, 9) < 8);
      r = $urandom_range(0, 99);
      if (r < 45) req_op = 2'b01;
      else if (r < 75) req_op = 2'b10;
      else if (r < 85) req_op = 2'b11;
      else req_op = 2'b00;
      pc_current = PC_W'($urandom);
      call_addr  = ADDR_W'($urandom);
      irq        = ($urandom_range(0, 11) == 0);
      #1;
      // A pending pop response means the controller is waiting on stack data.
      busy = e1_v;
      take = !busy && irq && !m_isr && !m_fault;
      rdy  = !busy && !m_fault && !take;
      n_assert++; if (req_ready !== rdy || irq_ack !== take) begin n_fail++; $display("FAIL rnd_hs c=%0d got rdy=%b ack=%b want %b/%b", c, req_ready, irq_ack, rdy, take); end
      n1_v = 0; n1_pc = '0; n2_v = 0; n2_clr = 0; n2_pc = '0;
      if (take) begin
        if (stk.size() == DEPTH) begin m_fault = 1; m_code = 2'b01; end
        else begin stk.push_back(pc_current); m_isr = 1; n1_v = 1; n1_pc = INT_PC; end
      end else if (req_valid && rdy) begin
        case (req_op)
          2'b01: begin
            if (stk.size() >= CALL_CAP) begin m_fault = 1; m_code = 2'b01; end
            else begin stk.push_back(PC_W'(pc_current + 1)); n1_v = 1; n1_pc = PC_W'(call_addr); end
          end
          2'b10: begin
            if (stk.size() == 0) begin m_fault = 1; m_code = 2'b10; end
            else begin n2_v = 1; n2_pc = stk.pop_back(); end
          end
          2'b11: begin
            if (!m_isr) begin m_fault = 1; m_code = 2'b11; end
            else if (stk.size() == 0) begin m_fault = 1; m_code = 2'b10; end
            else begin n2_v = 1; n2_clr = 1; n2_pc = stk.pop_back(); end
          end
          default: ;
        endcase
      end
      tick();
      cur_v   = e1_v | n1_v;
      cur_pc  = e1_v ? e1_pc : n1_pc;
      cur_clr = e1_v & e1_clr;
      e1_v = n2_v; e1_pc = n2_pc; e1_clr = n2_clr;
      if (cur_clr) m_isr = 0;
      n_assert++; if (resp_valid !== cur_v || (cur_v && pc_next !== cur_pc)) begin n_fail++; $display("FAIL rnd_resp c=%0d got rv=%b pc=%h want %b/%h", c, resp_valid, pc_next, cur_v, cur_pc); end
      n_assert++; if (depth !== DW'(stk.size()) || in_isr !== m_isr) begin n_fail++; $display("FAIL rnd_state c=%0d got d=%0d isr=%b want %0d/%b", c, depth, in_isr, stk.size(), m_isr); end
      n_assert++; if (fault !== m_fault || fault_code !== m_code) begin n_fail++; $display("FAIL rnd_fault c=%0d got f=%b code=%b want %b/%b", c, fault, fault_code, m_fault, m_code); end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_nested_calls();
    test_irq_vs_call();
    test_overflow();
    test_irq_full();
    test_underflow_iret();
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/subroutine_seq.md
Name: subroutine_seq

Overview:
- Sequencing controller for the CPU's return-address stack.
- Accepts CALL/RET/IRET requests from decode through a valid/ready handshake and arbitrates them against an external interrupt request.
- Drives a synchronous-read stack memory and returns the next PC with a fixed latency.
- Sits between decode/execute and the PC register; raises sticky faults on stack overflow, stack underflow and illegal IRET.

Parameters:
- PC_W, 19, program counter width.
- ADDR_W, 11, call-target field width; zero-extended to PC_W.
- DEPTH, 16, return-stack entries (power of two).
- INT_VEC, 11'h7F0, interrupt entry address; zero-extended to PC_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_op  in  2  00 NOP, 01 CALL, 10 RET, 11 IRET.
- pc_current  in  PC_W  PC of the requesting instruction.
- call_addr  in  ADDR_W  CALL target.
- irq  in  1  level interrupt request.
- irq_ack  out  1  one-cycle pulse when the interrupt is taken.
- program_end  in  1  halt; blocks new requests and interrupts.
- resp_valid  out  1  one-cycle pulse; pc_next is valid.
- pc_next  out  PC_W  redirect target.
- in_isr  out  1  interrupt service in progress.
- depth  out  $clog2(DEPTH)+1  current entry count.
- fault  out  1  sticky error flag.
- fault_code  out  2  01 overflow, 10 underflow, 11 IRET outside ISR.

Behaviour:
- Reset values: all outputs 0; depth 0; state IDLE.
- States: IDLE, POP_WAIT, FAULT.
- req_ready = (state == IDLE) && !program_end && !fault && !irq_take. A request is accepted when req_valid && req_ready.
- irq_take = IDLE && irq && !in_isr && !program_end && !fault. It has priority over a simultaneous request; the request stays pending with ready low.
- CALL, not full:
  - Write mem[depth] = pc_current + 1; depth++.
  - Next cycle: resp_valid = 1, pc_next = zext(call_addr).
  - Latency 1.
- RET or IRET, not empty:
  - Issue read of mem[depth-1]; depth--; go to POP_WAIT.
  - In POP_WAIT: resp_valid = 1, pc_next = read data; return to IDLE.
  - Latency 2.
  - IRET also clears in_isr in the POP_WAIT cycle.
- IRQ taken:
  - Write mem[depth] = pc_current (the interrupted instruction re-executes); depth++; in_isr = 1.
  - irq_ack pulses in the same cycle.
  - Next cycle: resp_valid = 1, pc_next = zext(INT_VEC).
  - If the stack is full at that point: fault 01.
- Fault entry:
  - CALL at depth == DEPTH gives code 01.
  - RET/IRET at depth == 0 gives code 10.
  - IRET with in_isr == 0 gives code 11.
  - On any fault: no stack access, no resp_valid, state FAULT. FAULT is left only by reset.
- Concurrent events:
  - program_end rising during POP_WAIT: the pending response still completes, then the controller holds IDLE with ready low.
  - NOP with valid: accepted; no response, no state change.
  - Reset in any state: immediate return to reset values. Stack contents are don't-care.
- Arithmetic: depth does not wrap; all full/empty checks precede any update. pc_current + 1 wraps modulo 2^PC_W.

Optional Feature:
- Macro: SUBR_IRQ_RESERVE_EN.
- Defined: one stack entry is reserved for interrupt entry. CALL faults (code 01) at depth == DEPTH-1, while an IRQ may still push at depth DEPTH-1.
- Undefined: CALL and IRQ share all DEPTH entries; IRQ at full gives fault 01.

Decomposition:
- Package subr_pkg holds:
  - op encodings (OP_NOP, OP_CALL, OP_RET, OP_IRET)
  - fault codes (FLT_NONE, FLT_OVF, FLT_UNF, FLT_IRET)
  - the state enum
  - the default INT_VEC
- Sub-module ret_stack_mem: DEPTH x PC_W storage, synchronous write, registered read with one-cycle latency, no reset of the array.
- The FSM, arbitration and depth counter stay in subroutine_seq.

Test Plan:
- Nested calls: CALL pc=0x00010 addr=0x100, then CALL pc=0x00100 addr=0x200, then two RETs → pc_next sequence 0x00100, 0x00200, 0x00101, 0x00011; depth 1,2,1,0; RET response exactly 2 cycles after acceptance.
- Interrupt vs. request: irq and CALL asserted in the same cycle at pc=0x00050 → irq_ack pulse, req_ready 0, pc_next 0x007F0, in_isr 1. The held CALL is accepted next cycle. Its later IRET returns 0x00050 and clears in_isr.
- Overflow: DEPTH CALLs then one more → fault=1, code 01, no resp_valid, req_ready stays 0 until reset. With SUBR_IRQ_RESERVE_EN, the fault occurs on call number DEPTH.
- Underflow and illegal IRET: RET at depth 0 → code 10. After reset, IRET with in_isr=0 and depth 1 → code 11; depth stays 1.
- Halt: program_end asserted during POP_WAIT → that response is still delivered; afterwards req_ready 0 and irq ignored (no irq_ack).
- Reset mid-operation: reset during POP_WAIT → next cycle depth 0, resp_valid 0, fault 0, in_isr 0, state IDLE.
